// File: rtl/weight_ddr_fetch_pkg.sv
// Shared constants and fetch FSM state type for the weight DDR fetch engine.
package weight_ddr_fetch_pkg;

  localparam int DDR_BEAT_BYTES  = 32;
  localparam int PAGE_BYTES      = 4096;
  localparam int BEATS_PER_BLOCK = 81;

  // Derived geometry: beats per 4 KB page and the address bits that index them.
  localparam int PAGE_BEATS = PAGE_BYTES / DDR_BEAT_BYTES;
  localparam int BEAT_SHIFT = $clog2(DDR_BEAT_BYTES);
  localparam int PAGE_SHIFT = $clog2(PAGE_BYTES);
  localparam int PAGE_IDX_W = PAGE_SHIFT - BEAT_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/weight_burst_len_calc.sv
// Burst length selection: the smallest of the burst limit, the beats still
// owed to the fetch, and the beats left before the next 4 KB page boundary.
module weight_burst_len_calc
  import weight_ddr_fetch_pkg::*;
#(
  parameter int BURST_LEN      = 16,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic [BEAT_CNT_WIDTH-1:0] remaining,
  input  logic [PAGE_IDX_W-1:0]     page_idx,
  output logic [8:0]                len
);

  logic [8:0] page_left;
  logic [8:0] cand;

  // Narrow the candidate length step by step; page_left is always 1..PAGE_BEATS.
  always_comb begin
    page_left = 9'(PAGE_BEATS) - 9'(page_idx);
    cand      = 9'(BURST_LEN);
    if (remaining < BEAT_CNT_WIDTH'(cand)) cand = remaining[8:0];
    if (page_left < cand) cand = page_left;
    len = cand;
  end

endmodule

// File: rtl/weight_ddr_fetch.sv
// Weight fetch engine: reads block_num blocks of weight beats from DDR, one
// burst in flight at a time, and forwards every beat one cycle later to the
// weight memory path, which cannot stall.
module weight_ddr_fetch
  import weight_ddr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DDR_RD_WIDTH    = 256,
  parameter int BURST_LEN       = 16,
  parameter int BEATS_PER_BLOCK = weight_ddr_fetch_pkg::BEATS_PER_BLOCK,
  parameter int BLK_CNT_WIDTH   = 8,
  parameter int BEAT_CNT_WIDTH  = 16
) (
  input  logic                      sys_clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [BLK_CNT_WIDTH-1:0]  block_num,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      ddr_arvalid,
  input  logic                      ddr_arready,
  output logic [ADDR_WIDTH-1:0]     ddr_araddr,
  output logic [7:0]                ddr_arlen,
  input  logic                      ddr_rvalid,
  output logic                      ddr_rready,
  input  logic [DDR_RD_WIDTH-1:0]   ddr_rdata,
  input  logic                      ddr_rlast,
  output logic [DDR_RD_WIDTH-1:0]   DDR_data_out,
  output logic                      DDR_valid_out
);

  localparam int LEN_W = 9;

  fetch_state_t              state, next_state;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [BEAT_CNT_WIDTH-1:0] remaining;
  logic [LEN_W-1:0]          beat_cnt;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          len_calc;
  logic                      err_q;
  logic                      beat_p0;
  logic                      last_beat_p0;
  logic                      vld_p1;
  logic [DDR_RD_WIDTH-1:0]   data_p1;

  assign beat_p0       = ddr_rvalid & ddr_rready;
  assign last_beat_p0  = beat_p0 && (beat_cnt == LEN_W'(1));
  assign err           = err_q;
  assign DDR_valid_out = vld_p1;
  assign DDR_data_out  = data_p1;

  weight_burst_len_calc #(
    .BURST_LEN      (BURST_LEN),
    .BEAT_CNT_WIDTH (BEAT_CNT_WIDTH)
  ) u_len_calc (
    .remaining (remaining),
    .page_idx  (addr[PAGE_SHIFT-1:BEAT_SHIFT]),
    .len       (len_calc)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the beat counter, not rlast, decides where a burst ends.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = (block_num == '0) ? ST_DONE : ST_REQ;
      ST_REQ:  if (ddr_arready) next_state = ST_DATA;
      ST_DATA: if (last_beat_p0)
                 next_state = (remaining == BEAT_CNT_WIDTH'(1)) ? ST_DONE : ST_REQ;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; the request fields read as zero outside REQ.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    ddr_arvalid = (state == ST_REQ);
    ddr_rready  = (state == ST_DATA);
    ddr_araddr  = '0;
    ddr_arlen   = '0;
    if (state == ST_REQ) begin
      ddr_araddr = addr;
      ddr_arlen  = 8'(len_calc - LEN_W'(1));
    end
  end

  // Fetch counters, burst address and sticky error flag.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr      <= base_addr;
        remaining <= BEAT_CNT_WIDTH'(block_num) * BEAT_CNT_WIDTH'(BEATS_PER_BLOCK);
        err_q     <= 1'b0;
      end
      if (state == ST_REQ && ddr_arready) begin
        beat_cnt <= len_calc;
        len_q    <= len_calc;
      end
      if (beat_p0) begin
        beat_cnt  <= beat_cnt - LEN_W'(1);
        remaining <= remaining - BEAT_CNT_WIDTH'(1);
        if (ddr_rlast != (beat_cnt == LEN_W'(1))) err_q <= 1'b1;
        if (beat_cnt == LEN_W'(1))
          addr <= addr + (ADDR_WIDTH'(len_q) << BEAT_SHIFT);
      end
    end
  end

  // ---- stage p0 -> p1: accepted read beat registered toward the weight memory ----
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= beat_p0;
      if (beat_p0) data_p1 <= ddr_rdata;
    end
  end

endmodule

// File: tb/tb_weight_ddr_fetch.sv
// Bench for weight_ddr_fetch: a DDR read-slave plus a reference model that
// plans the expected bursts from base address and block count, and a
// per-cycle comparison of the forwarded beat stream and done pulse.
module tb_weight_ddr_fetch;

  logic         sys_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [7:0]   block_num = '0;
  logic         busy, done, err;
  logic         ddr_arvalid;
  logic         ddr_arready = 1'b0;
  logic [31:0]  ddr_araddr;
  logic [7:0]   ddr_arlen;
  logic         ddr_rvalid = 1'b0;
  logic         ddr_rready;
  logic [255:0] ddr_rdata = '0;
  logic         ddr_rlast = 1'b0;
  logic [255:0] DDR_data_out;
  logic         DDR_valid_out;

  weight_ddr_fetch dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .start         (start),
    .base_addr     (base_addr),
    .block_num     (block_num),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .ddr_arvalid   (ddr_arvalid),
    .ddr_arready   (ddr_arready),
    .ddr_araddr    (ddr_araddr),
    .ddr_arlen     (ddr_arlen),
    .ddr_rvalid    (ddr_rvalid),
    .ddr_rready    (ddr_rready),
    .ddr_rdata     (ddr_rdata),
    .ddr_rlast     (ddr_rlast),
    .DDR_data_out  (DDR_data_out),
    .DDR_valid_out (DDR_valid_out)
  );

  always #5 sys_clk = ~sys_clk;

  int vec = 0;
  int miss = 0;
  int cyc = 0;

  // Model state: planned bursts, expected output stream, expected done cycle.
  logic [31:0]  pa_q[$];
  int           pl_q[$];
  logic [255:0] ed_q[$];
  int           ec_q[$];
  int           done_cyc = -1;
  int           total = -1;
  int           delivered = 0;
  bit           err_exp = 1'b0;

  // Slave controls set by the directed sequence.
  int r_left = 0;
  int g_idx = 0;
  int ar_stall = 0;
  bit gaps = 1'b0;
  int bad_g = -1;
  bit abandon = 1'b0;

  // Observations for the literal checks.
  int          obs_beats = 0;
  int          busy_cycles = 0;
  int          ar_cnt = 0;
  int          arvalid_seen = 0;
  int          done_at = -1;
  logic [31:0] ar_addr_log[$];
  int          ar_len_log[$];
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] beat_data(input int g);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(g);
    return {w, ~w, w ^ 32'h5A5A_A5A5, w + 32'd1, {w[15:0], w[31:16]}, ~w + 32'd3, w << 1, w >> 1};
  endfunction

  // Expected bursts: walk the fetch with min(16, remaining, beats to 4 KB edge).
  task automatic plan(input logic [31:0] base, input int nblk);
    logic [31:0] a;
    int rem, len, pg;
    pa_q.delete(); pl_q.delete(); ar_addr_log.delete(); ar_len_log.delete();
    obs_beats = 0; busy_cycles = 0; ar_cnt = 0; arvalid_seen = 0; done_at = -1;
    delivered = 0; err_exp = 1'b0;
    total = nblk * 81;
    a = base;
    rem = total;
    while (rem > 0) begin
      pg = (4096 - int'(a % 32'd4096)) / 32;
      len = 16;
      if (rem < len) len = rem;
      if (pg < len) len = pg;
      pa_q.push_back(a);
      pl_q.push_back(len);
      a = a + 32'(len * 32);
      rem -= len;
    end
    done_cyc = (nblk == 0) ? cyc + 1 : -1;
  endtask

  // DDR slave and per-cycle comparison, all on the falling edge.
  always @(negedge sys_clk) begin
    cyc++;
    if (abandon) begin
      ed_q.delete(); ec_q.delete(); pa_q.delete(); pl_q.delete();
      r_left = 0; done_cyc = -1; total = -1; prev_wait = 1'b0; abandon = 1'b0;
    end
    if (ec_q.size() > 0 && ec_q[0] == cyc) begin
      check("valid_out", DDR_valid_out, 1);
      check("data_out", DDR_data_out, ed_q[0]);
      void'(ec_q.pop_front());
      void'(ed_q.pop_front());
    end else begin
      check("valid_out_idle", DDR_valid_out, 0);
    end
    check("done", done, cyc == done_cyc);
    if (DDR_valid_out) obs_beats++;
    if (busy) busy_cycles++;
    if (ddr_arvalid) arvalid_seen++;
    if (done) done_at = cyc;
    if (prev_wait) begin
      check("arvalid_hold", ddr_arvalid, 1);
      check("araddr_hold", ddr_araddr, prev_addr);
      check("arlen_hold", ddr_arlen, prev_len);
    end
    if (r_left > 0) check("rready", ddr_rready, 1);

    // R channel: one beat per cycle unless a gap is scheduled.
    if (r_left > 0 && !(gaps && ((cyc % 4 == 1) || (cyc % 7 == 3)))) begin
      ddr_rvalid = 1'b1;
      ddr_rdata  = beat_data(g_idx);
      ddr_rlast  = (r_left == 1) || (g_idx == bad_g);
      if (ddr_rready) begin
        if (g_idx == bad_g) err_exp = 1'b1;
        ed_q.push_back(ddr_rdata);
        ec_q.push_back(cyc + 1);
        r_left--;
        g_idx++;
        delivered++;
        if (delivered == total) done_cyc = cyc + 1;
      end
    end else begin
      ddr_rvalid = 1'b0;
      ddr_rlast  = 1'b0;
    end

    // AR channel: optional stall, then accept and compare with the plan.
    ddr_arready = (ar_stall == 0);
    if (ddr_arvalid && ar_stall > 0) ar_stall--;
    prev_wait = ddr_arvalid && !ddr_arready;
    prev_addr = ddr_araddr;
    prev_len  = ddr_arlen;
    if (ddr_arvalid && ddr_arready) begin
      ar_cnt++;
      ar_addr_log.push_back(ddr_araddr);
      ar_len_log.push_back(int'(ddr_arlen));
      if (pa_q.size() == 0) begin
        check("unplanned_burst", 1, 0);
      end else begin
        check("araddr", ddr_araddr, pa_q[0]);
        check("arlen", ddr_arlen, 8'(pl_q[0] - 1));
        void'(pa_q.pop_front());
        void'(pl_q.pop_front());
      end
      r_left = int'(ddr_arlen) + 1;
    end
  end

  task automatic start_fetch(input logic [31:0] base, input int nblk, output int s);
    @(negedge sys_clk); #1;
    plan(base, nblk);
    s = cyc;
    base_addr = base;
    block_num = 8'(nblk);
    start = 1'b1;
    @(negedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_at < 0 && n < 3000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    check({name, "_done_seen"}, done_at >= 0, 1);
    @(negedge sys_clk); #1;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_stream_drained"}, ec_q.size() + pa_q.size(), 0);
    check({name, "_err"}, err, err_exp);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_err"}, err, 0);
    check({name, "_arvalid"}, ddr_arvalid, 0);
    check({name, "_rready"}, ddr_rready, 0);
    check({name, "_araddr"}, ddr_araddr, 0);
    check({name, "_arlen"}, ddr_arlen, 0);
    check({name, "_data_out"}, DDR_data_out, 0);
    check({name, "_valid_out"}, DDR_valid_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int e1[6] = '{15, 15, 15, 15, 15, 0};

    // Reset state.
    repeat (3) @(negedge sys_clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: one block from 0x0, no stalls: five 16-beat bursts plus one single beat.
    start_fetch(32'h0, 1, s);
    wait_done("t1");
    check("t1_burst_count", ar_len_log.size(), 6);
    for (int i = 0; i < 6 && i < ar_len_log.size(); i++)
      check("t1_arlen_literal", ar_len_log[i], e1[i]);
    check("t1_beats", obs_beats, 81);
    check("t1_done_latency", done_at - s, 88);
    check("t1_busy_cycles", busy_cycles, 88);

    // 2: start 4 beats short of a page edge.
    start_fetch(32'hF80, 1, s);
    wait_done("t2");
    check("t2_addr0", ar_addr_log[0], 32'hF80);
    check("t2_len0", ar_len_log[0], 3);
    check("t2_addr1", ar_addr_log[1], 32'h1000);
    check("t2_len1", ar_len_log[1], 15);
    for (int i = 0; i < ar_addr_log.size(); i++)
      check("t2_no_4k_cross", (int'(ar_addr_log[i] % 32'd4096) + (ar_len_log[i] + 1) * 32) > 4096, 0);
    check("t2_beats", obs_beats, 81);

    // 3: zero blocks: done in the cycle right after start is taken, no request.
    start_fetch(32'h100, 0, s);
    wait_done("t3");
    check("t3_arvalid_seen", arvalid_seen, 0);
    check("t3_busy_cycles", busy_cycles, 1);
    check("t3_done_latency", done_at - s, 1);

    // 4: 10-cycle arready stall and rvalid gaps over two blocks.
    ar_stall = 10;
    gaps = 1'b1;
    start_fetch(32'h0001_0040, 2, s);
    wait_done("t4");
    check("t4_beats", obs_beats, 162);
    check("t4_burst_gt_stall", (done_at - s) > 172, 1);
    gaps = 1'b0;

    // 5: early rlast on beat 5 of the first burst sets a sticky err.
    bad_g = g_idx + 4;
    start_fetch(32'h4000, 1, s);
    wait_done("t5");
    check("t5_beats", obs_beats, 81);
    check("t5_err_literal", err, 1);
    repeat (3) @(negedge sys_clk);
    #1;
    check("t5_err_sticky", err, 1);
    bad_g = -1;
    start_fetch(32'h5000, 1, s);
    check("t5_err_cleared", err, 0);
    wait_done("t5b");

    // 6: reset mid-burst, then a clean fetch that starts 1 beat before a page edge.
    gaps = 1'b1;
    start_fetch(32'h6000, 2, s);
    repeat (40) @(negedge sys_clk);
    #1;
    rstn = 1'b0;
    abandon = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge sys_clk);
    #1;
    check_reset_outputs("t6_held");
    rstn = 1'b1;
    gaps = 1'b0;
    start_fetch(32'h7FE0, 1, s);
    wait_done("t6");
    check("t6_addr0", ar_addr_log[0], 32'h7FE0);
    check("t6_len0", ar_len_log[0], 0);
    check("t6_addr1", ar_addr_log[1], 32'h8000);
    check("t6_beats", obs_beats, 81);

    // 7: a second start while busy is ignored.
    start_fetch(32'h0, 1, s);
    repeat (20) @(negedge sys_clk);
    #1;
    base_addr = 32'h9000;
    block_num = 8'd3;
    start = 1'b1;
    @(negedge sys_clk); #1;
    start = 1'b0;
    wait_done("t7");
    check("t7_beats", obs_beats, 81);
    check("t7_bursts", ar_cnt, 6);
    check("t7_done_latency", done_at - s, 88);

    // Address wrap at the top of the address space.
    start_fetch(32'hFFFF_FFE0, 1, s);
    wait_done("wrap");
    check("wrap_len0", ar_len_log[0], 0);
    check("wrap_addr1", ar_addr_log[1], 32'h0);
    check("wrap_len1", ar_len_log[1], 15);
    check("wrap_beats", obs_beats, 81);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
